apb_master_arb: RTL

//  APB master that shares one APB bus between NREQ requesters (e.g. CPU bridge and DMA).

---
 rtl/apb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/apb_master_arb.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB master/arbiter slice.
// Holds the FSM state encoding, default bus widths and APB pprot encodings.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  // pprot bit meanings: [0] privileged, [1] non-secure, [2] instruction
  localparam logic [2:0] PPROT_NORMAL = 3'b000;
  localparam logic [2:0] PPROT_PRIV   = 3'b001;
  localparam logic [2:0] PPROT_NONSEC = 3'b010;
  localparam logic [2:0] PPROT_INSTR  = 3'b100;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping to the lowest index below ptr_i when nothing is found above it.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic             hit_hi, hit_lo;
  logic [IDX_W-1:0] idx_hi, idx_lo;

  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    // Scanning downwards lets the lowest matching index win in each half.
    for (int c = NREQ - 1; c >= 0; c--) begin
      if (req_i[c]) begin
        if (IDX_W'(c) >= ptr_i) begin
          hit_hi = 1'b1;
          idx_hi = IDX_W'(c);
        end else begin
          hit_lo = 1'b1;
          idx_lo = IDX_W'(c);
        end
      end
    end
    grant_idx_o = hit_hi ? idx_hi : idx_lo;
    grant_o     = (hit_hi || hit_lo) ? (NREQ'(1) << grant_idx_o) : '0;
  end

endmodule

// File: rtl/apb_master_arb.sv
// APB master shared by NREQ requesters: round-robin grant in IDLE, then SETUP and
// ACCESS phases, with a watchdog that forces an error completion on a stalled slave.
module apb_master_arb
  import apb_pkg::*;
#(
  parameter int         NREQ    = 2,
  parameter int         ADDR_W  = ADDR_W_DEF,
  parameter int         DATA_W  = DATA_W_DEF,
  parameter int         TIMEOUT = 16,
  parameter logic [2:0] PPROT   = PPROT_NORMAL
) (
  input  logic                       pclk,
  input  logic                       prst,
  input  logic [NREQ-1:0]            rq_valid,
  output logic [NREQ-1:0]            rq_ready,
  input  logic [NREQ-1:0]            rq_write,
  input  logic [NREQ*ADDR_W-1:0]     rq_addr,
  input  logic [NREQ*DATA_W-1:0]     rq_wdata,
  input  logic [NREQ*DATA_W/8-1:0]   rq_strb,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  output logic [ADDR_W-1:0]          paddr,
  output logic [DATA_W-1:0]          pwdata,
  output logic [DATA_W/8-1:0]        pstrb,
  output logic [2:0]                 pprot,
  input  logic [DATA_W-1:0]          prdata,
  input  logic                       pready,
  input  logic                       pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_e        state_q;
  logic [IDX_W-1:0]  ptr_q, ptr_d, gnt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              psel_q, penable_q, pwrite_q, rsp_err_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q, rsp_rdata_q;
  logic [STRB_W-1:0] pstrb_q;
  logic [NREQ-1:0]   rsp_valid_q;

  logic [NREQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_strb;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req_i       (rq_valid),
    .ptr_i       (ptr_q),
    .grant_o     (arb_gnt),
    .grant_idx_o (arb_idx)
  );

  // arb_gnt is one-hot (or zero), so an OR-mux picks the granted command.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_strb  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        sel_write = sel_write | rq_write[i];
        sel_addr  = sel_addr  | rq_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = sel_wdata | rq_wdata[i*DATA_W +: DATA_W];
        sel_strb  = sel_strb  | rq_strb[i*STRB_W +: STRB_W];
      end
    end
    ptr_d = (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (|rq_valid) begin
            gnt_q    <= arb_idx;
            ptr_q    <= ptr_d;
            cnt_q    <= '0;
            pwrite_q <= sel_write;
            paddr_q  <= sel_addr;
            pwdata_q <= sel_wdata;
            pstrb_q  <= sel_write ? sel_strb : '0;
            psel_q   <= 1'b1;
            state_q  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready || cnt_q == CNT_LAST) begin
            rsp_rdata_q <= (pready && !pwrite_q) ? prdata : '0;
            rsp_err_q   <= pready ? pslverr : 1'b1;
            rsp_valid_q <= NREQ'(1) << gnt_q;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rq_ready  = (state_q == ST_IDLE && !prst) ? arb_gnt : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign pprot     = PPROT;

endmodule
